// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges EXU and LSU results onto the single register-file write port
// with round-robin arbitration, one output register stage and a per-register busy scoreboard. Rev 1.0
`default_nettype none

module rf_writeback_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int ADDR_COUNT = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic [ADDR_WIDTH-1:0] exu_waddr,
   input  logic [DATA_WIDTH-1:0] exu_wdata,

   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_waddr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,

   input  logic                  claim_valid,
   input  logic [ADDR_WIDTH-1:0] claim_addr,
   output logic [ADDR_COUNT-1:0] busy,

   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

   // favour_lsu=0 gives EXU the grant when both producers request together
   logic                  favour_lsu;
   logic                  both_valid;
   logic                  any_fire;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  win_nonzero;
   logic [ADDR_COUNT-1:0] busy_q;
   logic [ADDR_COUNT-1:0] busy_next;

   always_comb begin
      both_valid  = exu_valid && lsu_valid;
      exu_ready   = exu_valid && !(lsu_valid && favour_lsu);
      lsu_ready   = lsu_valid && !(exu_valid && !favour_lsu);
      any_fire    = exu_ready || lsu_ready;
      win_addr    = lsu_ready ? lsu_waddr : exu_waddr;
      win_data    = lsu_ready ? lsu_wdata : exu_wdata;
      win_nonzero = (win_addr != ZERO_ADDR);
   end

   // Clear on writeback first, then set on claim, so a same-address claim wins.
   always_comb begin
      busy_next = busy_q;
      if (any_fire && win_nonzero) begin
         busy_next[win_addr] = 1'b0;
      end
      if (claim_valid && (claim_addr != ZERO_ADDR)) begin
         busy_next[claim_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         favour_lsu <= 1'b0;
         busy_q     <= '0;
         rf_wen     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         busy_q <= busy_next;
         // After a conflict the loser becomes favoured; single grants keep the pointer.
         if (both_valid) begin
            favour_lsu <= exu_ready;
         end
         rf_wen <= any_fire && win_nonzero;
         if (any_fire) begin
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
         end
      end
   end

   assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed vector table plus randomized run against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_rf_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic        exu_valid;
   logic        exu_ready;
   logic [4:0]  exu_waddr;
   logic [31:0] exu_wdata;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_waddr;
   logic [31:0] lsu_wdata;
   logic        claim_valid;
   logic [4:0]  claim_addr;
   logic [31:0] busy;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int n_pass  = 0;
   int n_total = 0;

   rf_writeback_arbiter #(
      .ADDR_WIDTH(5),
      .ADDR_COUNT(32),
      .DATA_WIDTH(32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .exu_valid  (exu_valid),
      .exu_ready  (exu_ready),
      .exu_waddr  (exu_waddr),
      .exu_wdata  (exu_wdata),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_waddr  (lsu_waddr),
      .lsu_wdata  (lsu_wdata),
      .claim_valid(claim_valid),
      .claim_addr (claim_addr),
      .busy       (busy),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ev;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        cv;
      logic [4:0]  ca;
      logic        x_er;
      logic        x_lr;
      logic        x_wen;
      logic [4:0]  x_wa;
      logic [31:0] x_wd;
      logic [31:0] x_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic ev, logic [4:0] ea, logic [31:0] ed,
                               logic lv, logic [4:0] la, logic [31:0] ld,
                               logic cv, logic [4:0] ca,
                               logic x_er, logic x_lr, logic x_wen,
                               logic [4:0] x_wa, logic [31:0] x_wd, logic [31:0] x_busy);
      vec_t v;
      v.rst = r;   v.ev = ev;  v.ea = ea;  v.ed = ed;
      v.lv = lv;   v.la = la;  v.ld = ld;  v.cv = cv;  v.ca = ca;
      v.x_er = x_er; v.x_lr = x_lr; v.x_wen = x_wen;
      v.x_wa = x_wa; v.x_wd = x_wd; v.x_busy = x_busy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic r, input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic cv, input logic [4:0] ca);
      rst = r;
      exu_valid = ev; exu_waddr = ea; exu_wdata = ed;
      lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
      claim_valid = cv; claim_addr = ca;
   endtask

   task automatic check_outputs(input string tag, input logic wen, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] bz);
      check({tag, " rf_wen"},   {31'd0, rf_wen},  {31'd0, wen});
      check({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, wa});
      check({tag, " rf_wdata"}, rf_wdata, wd);
      check({tag, " busy"},     busy, bz);
   endtask

   // Behavioural model state
   logic        m_fav_lsu;
   logic [31:0] m_busy;
   logic        m_wen;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   initial begin
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

      // Directed vectors: inputs applied for one cycle, readies checked before the edge,
      // registered outputs and busy checked after it.
      tbl.push_back(mk(1,0,0,0,          0,0,0,          0,0,  0,0, 0,0,0,                   0));
      tbl.push_back(mk(0,1,5,32'hDEADBEEF,0,0,0,         0,0,  1,0, 1,5,32'hDEADBEEF,        0));
      tbl.push_back(mk(0,0,0,0,          0,0,0,          0,0,  0,0, 0,5,32'hDEADBEEF,        0));
      tbl.push_back(mk(0,1,3,32'h11,     1,4,32'h22,     0,0,  1,0, 1,3,32'h11,              0));
      tbl.push_back(mk(0,0,0,0,          1,4,32'h22,     0,0,  0,1, 1,4,32'h22,              0));
      tbl.push_back(mk(0,0,0,0,          0,0,0,          0,0,  0,0, 0,4,32'h22,              0));
      tbl.push_back(mk(1,0,0,0,          0,0,0,          0,0,  0,0, 0,0,0,                   0));
      tbl.push_back(mk(0,1,10,32'hA,     1,11,32'hB,     0,0,  1,0, 1,10,32'hA,              0));
      tbl.push_back(mk(0,1,10,32'hA,     1,11,32'hB,     0,0,  0,1, 1,11,32'hB,              0));
      tbl.push_back(mk(0,1,10,32'hA,     1,11,32'hB,     0,0,  1,0, 1,10,32'hA,              0));
      tbl.push_back(mk(0,1,10,32'hA,     1,11,32'hB,     0,0,  0,1, 1,11,32'hB,              0));
      tbl.push_back(mk(0,0,0,0,          1,0,32'hFFFFFFFF,0,0, 0,1, 0,0,32'hFFFFFFFF,        0));
      tbl.push_back(mk(0,0,0,0,          0,0,0,          1,7,  0,0, 0,0,32'hFFFFFFFF,        32'h80));
      tbl.push_back(mk(0,1,7,32'h77,     0,0,0,          1,7,  1,0, 1,7,32'h77,              32'h80));
      tbl.push_back(mk(0,1,7,32'h78,     0,0,0,          0,0,  1,0, 1,7,32'h78,              0));
      tbl.push_back(mk(0,0,0,0,          0,0,0,          1,12, 0,0, 0,7,32'h78,              32'h1000));
      tbl.push_back(mk(0,1,12,32'hC,     0,0,0,          1,13, 1,0, 1,12,32'hC,              32'h2000));
      tbl.push_back(mk(0,0,0,0,          1,13,32'hD,     1,0,  0,1, 1,13,32'hD,              0));
      tbl.push_back(mk(0,1,1,32'h31,     1,2,32'h32,     1,6,  1,0, 1,1,32'h31,              32'h40));
      tbl.push_back(mk(1,1,3,32'h5,      1,4,32'h6,      1,9,  0,1, 0,0,0,                   0));
      tbl.push_back(mk(0,1,1,32'h1,      1,2,32'h2,      0,0,  1,0, 1,1,32'h1,               0));

      // Reset held two cycles while EXU requests.
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset", 1'b0, 5'd0, 32'd0, 32'd0);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      @(posedge clk); #1;
      check_outputs("post_reset_idle", 1'b0, 5'd0, 32'd0, 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(tbl[i].rst, tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].lv, tbl[i].la, tbl[i].ld,
               tbl[i].cv, tbl[i].ca);
         #1;
         check({tag, " exu_ready"}, {31'd0, exu_ready}, {31'd0, tbl[i].x_er});
         check({tag, " lsu_ready"}, {31'd0, lsu_ready}, {31'd0, tbl[i].x_lr});
         @(posedge clk); #1;
         check_outputs(tag, tbl[i].x_wen, tbl[i].x_wa, tbl[i].x_wd, tbl[i].x_busy);
      end

      // Randomized run against the model; producers hold their request until granted.
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      @(posedge clk); #1;
      m_fav_lsu = 1'b0; m_busy = '0; m_wen = 1'b0; m_wa = '0; m_wd = '0;
      begin
         logic        ev, lv;
         logic [4:0]  ea, la;
         logic [31:0] ed, ld;
         int          win;
         ev = 1'b0; lv = 1'b0; ea = '0; la = '0; ed = '0; ld = '0;
         for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!ev) begin
               ev = ($urandom_range(0, 3) != 0);
               ea = 5'($urandom_range(0, 31));
               ed = $urandom;
            end
            if (!lv) begin
               lv = ($urandom_range(0, 3) != 0);
               la = 5'($urandom_range(0, 31));
               ld = $urandom;
            end
            drive(($urandom_range(0, 99) == 0), ev, ea, ed, lv, la, ld,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
            #1;
            if (ev && lv) win = m_fav_lsu ? 2 : 1;
            else if (ev)  win = 1;
            else if (lv)  win = 2;
            else          win = 0;
            check("rand exu_ready", {31'd0, exu_ready}, {31'd0, (win == 1)});
            check("rand lsu_ready", {31'd0, lsu_ready}, {31'd0, (win == 2)});
            @(posedge clk); #1;
            if (rst) begin
               m_fav_lsu = 1'b0; m_busy = '0; m_wen = 1'b0; m_wa = '0; m_wd = '0;
            end else begin
               m_wen = 1'b0;
               if (win != 0) begin
                  m_wa  = (win == 1) ? ea : la;
                  m_wd  = (win == 1) ? ed : ld;
                  m_wen = (m_wa != 0);
                  if (m_wa != 0) m_busy[m_wa] = 1'b0;
                  if (ev && lv) m_fav_lsu = (win == 1);
               end
               if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
            end
            check_outputs("rand", m_wen, m_wa, m_wd, m_busy);
            if (win == 1) ev = 1'b0;
            if (win == 2) lv = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
